aes_decipher_block: RTL and testbench
=====================================

Name: aes_decipher_block

Overview:
Iterative AES decipher datapath controller. It accepts one 128-bit ciphertext block and runs one round per clock through the combinational decipher round logic. Round keys come from the external key memory, which it indexes in descending order. It sits between the core's API/control layer and the key memory, and delivers the 128-bit plaintext with a ready flag.

Parameters:
None. Round counts and round-type encodings are package constants.

Ports:
clk        in   1    system clock, all state on rising edge
reset_n    in   1    asynchronous active-low reset
next       in   1    single-cycle start strobe, accepted only when ready=1
keylen     in   1    0 = AES-128 (Nr=10), 1 = AES-256 (Nr=14); sampled with next
round      out  4    round-key index to key memory (combinational from round counter)
round_key  in   128  key for index "round", valid same cycle (combinational key-memory read)
block      in   128  ciphertext, sampled with next; byte 0 = bits [127:120], column-major state
new_block  out  128  plaintext result, stable while ready=1
ready      out  1    1 = idle with result valid; 0 = busy

Behaviour:
- Reset (async assert, sync-released use): ready=1, new_block=0, round counter=0, FSM=IDLE, internal state=0. Reset mid-operation aborts immediately with no partial result.
- FSM states: IDLE, INIT, MAIN, FINAL.
  - IDLE: if next && ready, latch block into state reg, latch keylen, round_ctr <= Nr, ready <= 0, go INIT. next while busy is ignored with no effect.
  - INIT (1 cycle, round=Nr): state <= state ^ round_key. round_ctr <= Nr-1. Go MAIN.
  - MAIN (Nr-1 cycles, round=Nr-1 down to 1): state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ round_key). Decrement round_ctr. When round_ctr==1, go FINAL.
  - FINAL (1 cycle, round=0): new_block <= InvSubBytes(InvShiftRows(state)) ^ round_key. ready <= 1. round_ctr <= 0. Go IDLE.
- Latency: ready low for exactly Nr+1 cycles; 11 for AES-128, 15 for AES-256. ready rises on the edge ending FINAL, with new_block valid in the same cycle.
- round output: equals round_ctr in every state; 0 in IDLE.
  - Key-index sequence for AES-128: 10,9,...,1,0.
  - Key-index sequence for AES-256: 14,...,0.
- new_block is updated only at FINAL. It holds its value through IDLE and through the whole of the next operation.
- next asserted in the same cycle ready rises: not accepted (ready is still 0 that cycle). next in the following cycle is accepted (back-to-back throughput of Nr+2 cycles per block).
- keylen or block changes while busy have no effect.
- All GF(2^8) arithmetic is mod x^8+x^4+x^3+x+1. InvMixColumns coefficients are {0e,0b,0d,09}.

Decomposition:
- Package aes_pkg:
  - AES_128_ROUNDS=10, AES_256_ROUNDS=14
  - round-type encoding INIT_ROUND=0, MAIN_ROUND=1, FINAL_ROUND=2
  - FSM state encoding
  - GF multiply functions gm2..gm14
- Sub-module aes_decipher_round: the existing combinational one-round datapath. This block drives its round_type from the FSM state, its s00..s33 from the state register, and its round_key from the port. It captures the s*_new outputs.
- This block owns only the registers, counter and FSM.

Test Plan:
1. AES-128 (FIPS-197 C.1): key 000102030405060708090a0b0c0d0e0f expanded by bench model, block=69c4e0d86a7b0430d8cdb78070b4c55a, keylen=0, pulse next -> ready low exactly 11 cycles; new_block=00112233445566778899aabbccddeeff; round sequence 10..0.
2. AES-256 (FIPS-197 C.3): key 000102...1e1f, block=8ea2b7ca516745bfeafc49904b496089, keylen=1 -> ready low 15 cycles; new_block=00112233445566778899aabbccddeeff; round sequence 14..0.
3. Busy protection: during test 1, pulse next at cycle 4 with block=ffff...ff and keylen=1 -> result and latency unchanged vs test 1.
4. Back-to-back: issue the C.1 vector, then next on the first cycle after ready=1 with the same vector -> identical result. new_block holds the first result throughout the second run.
5. Reset mid-op: assert reset_n=0 at cycle 6 of an AES-128 run -> immediately ready=1, new_block=0, round=0. After release, a fresh C.1 run passes.
6. Post-reset idle: no next for 20 cycles -> ready=1, round=0, new_block=0 constant.

Source files
------------

// File: rtl/aes_decipher_block_pkg.sv
// Shared constants, enums and GF(2^8) helpers for the AES decipher block.
// No ports: imported by the interface, the round datapath and the top.
package aes_pkg;

  localparam int unsigned BLOCK_W        = 128;
  localparam int unsigned ROUND_W        = 4;
  localparam int unsigned AES_128_ROUNDS = 10;
  localparam int unsigned AES_256_ROUNDS = 14;

  // Selects which flavour of round the combinational datapath performs.
  typedef enum logic [1:0] {
    INIT_ROUND  = 2'd0,
    MAIN_ROUND  = 2'd1,
    FINAL_ROUND = 2'd2
  } round_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    MAIN  = 2'd2,
    FINAL = 2'd3
  } fsm_state_t;

  // Multiplication by constants in GF(2^8) mod x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm2(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] x);
    return gm2(x) ^ x;
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] x);
    return gm2(gm2(x));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] x);
    return gm2(gm4(x));
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] x);
    return gm8(x) ^ x;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] x);
    return gm8(x) ^ gm2(x) ^ x;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] x);
    return gm8(x) ^ gm4(x) ^ x;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] x);
    return gm8(x) ^ gm4(x) ^ gm2(x);
  endfunction

endpackage

// File: rtl/aes_decipher_block_if.sv
// Bundle between the control layer / key memory and the decipher block.
//   next, keylen, block : start strobe, key length select, ciphertext
//   round, round_key    : key-memory index out, round key back (same cycle)
//   new_block, ready    : plaintext result and idle/result-valid flag
interface aes_decipher_block_if;
  import aes_pkg::*;

  logic               next;
  logic               keylen;
  logic [BLOCK_W-1:0] block;
  logic [ROUND_W-1:0] round;
  logic [BLOCK_W-1:0] round_key;
  logic [BLOCK_W-1:0] new_block;
  logic               ready;

  modport master (
    output next, keylen, block, round_key,
    input  round, new_block, ready
  );

  modport slave (
    input  next, keylen, block, round_key,
    output round, new_block, ready
  );

endinterface

// File: rtl/aes_decipher_block_round.sv
// Combinational AES decipher round. State bytes are s<row><col>.
//   round_type : INIT (AddRoundKey), MAIN (full inverse round), FINAL (no mix)
//   round_key  : 128-bit key, byte 0 in bits [127:120], column-major
//   s00..s33   : current state bytes;  s00_new..s33_new : next state bytes
module aes_decipher_round
  import aes_pkg::*;
(
  input  round_type_t  round_type,
  input  logic [127:0] round_key,
  input  logic [7:0]   s00, s01, s02, s03,
  input  logic [7:0]   s10, s11, s12, s13,
  input  logic [7:0]   s20, s21, s22, s23,
  input  logic [7:0]   s30, s31, s32, s33,
  output logic [7:0]   s00_new, s01_new, s02_new, s03_new,
  output logic [7:0]   s10_new, s11_new, s12_new, s13_new,
  output logic [7:0]   s20_new, s21_new, s22_new, s23_new,
  output logic [7:0]   s30_new, s31_new, s32_new, s33_new
);

  // Inverse S-box, entry 0 in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Entry x sits at bit offset 8*(255-x), i.e. {~x, 3'b000}.
  function automatic logic [7:0] inv_sub(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return INV_SBOX[base +: 8];
  endfunction

  logic [15:0][7:0] key_bytes;
  logic [7:0] st  [4][4];
  logic [7:0] key [4][4];
  logic [7:0] sub [4][4];
  logic [7:0] mix [4][4];
  logic [7:0] res [4][4];

  assign key_bytes = round_key;

  // Gather port bytes into a row/column array.
  always_comb begin
    st[0][0] = s00; st[0][1] = s01; st[0][2] = s02; st[0][3] = s03;
    st[1][0] = s10; st[1][1] = s11; st[1][2] = s12; st[1][3] = s13;
    st[2][0] = s20; st[2][1] = s21; st[2][2] = s22; st[2][3] = s23;
    st[3][0] = s30; st[3][1] = s31; st[3][2] = s32; st[3][3] = s33;
  end

  // Byte index 4*c+r of the key lives in packed element 15-(4*c+r).
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        key[r][c] = key_bytes[4'(15 - 4 * c - r)];
      end
    end
  end

  // InvShiftRows (row r rotated right by r), InvSubBytes, AddRoundKey.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sub[r][c] = inv_sub(st[r][2'(c + 4 - r)]) ^ key[r][c];
      end
    end
  end

  // InvMixColumns with coefficients {0e,0b,0d,09}.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mix[0][c] = gm14(sub[0][c]) ^ gm11(sub[1][c]) ^ gm13(sub[2][c]) ^ gm9(sub[3][c]);
      mix[1][c] = gm9(sub[0][c])  ^ gm14(sub[1][c]) ^ gm11(sub[2][c]) ^ gm13(sub[3][c]);
      mix[2][c] = gm13(sub[0][c]) ^ gm9(sub[1][c])  ^ gm14(sub[2][c]) ^ gm11(sub[3][c]);
      mix[3][c] = gm11(sub[0][c]) ^ gm13(sub[1][c]) ^ gm9(sub[2][c])  ^ gm14(sub[3][c]);
    end
  end

  // Round-type select; INIT is a bare AddRoundKey.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        res[r][c] = st[r][c] ^ key[r][c];
      end
    end
    case (round_type)
      MAIN_ROUND:  res = mix;
      FINAL_ROUND: res = sub;
      default:     ;
    endcase
  end

  assign s00_new = res[0][0]; assign s01_new = res[0][1];
  assign s02_new = res[0][2]; assign s03_new = res[0][3];
  assign s10_new = res[1][0]; assign s11_new = res[1][1];
  assign s12_new = res[1][2]; assign s13_new = res[1][3];
  assign s20_new = res[2][0]; assign s21_new = res[2][1];
  assign s22_new = res[2][2]; assign s23_new = res[2][3];
  assign s30_new = res[3][0]; assign s31_new = res[3][1];
  assign s32_new = res[3][2]; assign s33_new = res[3][3];

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 decipher: one round per clock, keys fetched from an
// external key memory in descending index order.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : next/keylen/block in, round out, round_key in,
//                  new_block/ready out
module aes_decipher_block
  import aes_pkg::*;
(
  input logic                 clk,
  input logic                 reset_n,
  aes_decipher_block_if.slave bus
);

  fsm_state_t         fsm_state, fsm_next;
  logic [ROUND_W-1:0] round_ctr, ctr_next;
  logic [BLOCK_W-1:0] state_reg, state_next;
  logic [BLOCK_W-1:0] result_reg, result_next;
  logic               ready_reg, ready_next;
  round_type_t        round_type;
  logic [BLOCK_W-1:0] round_out;

  assign bus.round     = round_ctr;
  assign bus.new_block = result_reg;
  assign bus.ready     = ready_reg;

  aes_decipher_round u_round (
    .round_type (round_type),
    .round_key  (bus.round_key),
    .s00 (state_reg[127:120]), .s10 (state_reg[119:112]),
    .s20 (state_reg[111:104]), .s30 (state_reg[103:96]),
    .s01 (state_reg[95:88]),   .s11 (state_reg[87:80]),
    .s21 (state_reg[79:72]),   .s31 (state_reg[71:64]),
    .s02 (state_reg[63:56]),   .s12 (state_reg[55:48]),
    .s22 (state_reg[47:40]),   .s32 (state_reg[39:32]),
    .s03 (state_reg[31:24]),   .s13 (state_reg[23:16]),
    .s23 (state_reg[15:8]),    .s33 (state_reg[7:0]),
    .s00_new (round_out[127:120]), .s10_new (round_out[119:112]),
    .s20_new (round_out[111:104]), .s30_new (round_out[103:96]),
    .s01_new (round_out[95:88]),   .s11_new (round_out[87:80]),
    .s21_new (round_out[79:72]),   .s31_new (round_out[71:64]),
    .s02_new (round_out[63:56]),   .s12_new (round_out[55:48]),
    .s22_new (round_out[47:40]),   .s32_new (round_out[39:32]),
    .s03_new (round_out[31:24]),   .s13_new (round_out[23:16]),
    .s23_new (round_out[15:8]),    .s33_new (round_out[7:0])
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_state <= IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_ctr  <= '0;
      state_reg  <= '0;
      result_reg <= '0;
      ready_reg  <= 1'b1;
    end else begin
      round_ctr  <= ctr_next;
      state_reg  <= state_next;
      result_reg <= result_next;
      ready_reg  <= ready_next;
    end
  end

  // Next-state and datapath control. The round counter doubles as the
  // key-memory index, so loading it with Nr also captures keylen.
  always_comb begin
    fsm_next    = fsm_state;
    ctr_next    = round_ctr;
    state_next  = state_reg;
    result_next = result_reg;
    ready_next  = ready_reg;
    round_type  = INIT_ROUND;

    case (fsm_state)
      IDLE: begin
        if (bus.next && ready_reg) begin
          state_next = bus.block;
          ctr_next   = bus.keylen ? ROUND_W'(AES_256_ROUNDS) : ROUND_W'(AES_128_ROUNDS);
          ready_next = 1'b0;
          fsm_next   = INIT;
        end
      end
      INIT: begin
        round_type = INIT_ROUND;
        state_next = round_out;
        ctr_next   = round_ctr - ROUND_W'(1);
        fsm_next   = MAIN;
      end
      MAIN: begin
        round_type = MAIN_ROUND;
        state_next = round_out;
        ctr_next   = round_ctr - ROUND_W'(1);
        if (round_ctr == ROUND_W'(1)) begin
          fsm_next = FINAL;
        end
      end
      FINAL: begin
        round_type  = FINAL_ROUND;
        result_next = round_out;
        ready_next  = 1'b1;
        ctr_next    = '0;
        fsm_next    = IDLE;
      end
      default: begin
        fsm_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_aes_decipher_block.sv
// Bench for aes_decipher_block: acts as control layer and key memory, keeps
// an algorithmic AES model, and checks outputs on every falling clock edge.
module tb_aes_decipher_block;

  localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk;
  logic reset_n;
  logic run_sel;
  logic check_en;
  int   checks;
  int   errors;
  int   lat;
  int   round_log [$];

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [2][16];

  int           m_left;
  logic [127:0] m_result;
  logic [127:0] m_pending;

  aes_decipher_block_if bus ();

  aes_decipher_block dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Key memory: combinational read for the key length of the current run.
  assign bus.round_key = rk[run_sel][bus.round];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sboxes();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      logic [7:0] s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input int nk, input int sel);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nr;
    nr   = nk + 6;
    rcon = 8'h01;
    for (int r = 0; r < 16; r++) rk[sel][r] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = gmul(rcon, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk[sel][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  // Textbook inverse cipher on a byte array.
  function automatic logic [127:0] model_decrypt(input logic [127:0] ct, input logic sel);
    logic [7:0]   s    [16];
    logic [7:0]   t    [16];
    logic [7:0]   a    [4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] x;
    int nr;
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    nr = sel ? 14 : 10;
    x  = ct ^ rk[sel][nr];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) s[i] = x[127 - 8 * i -: 8];
      for (int i = 0; i < 16; i++) t[i] = inv_sbox[s[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)]];
      for (int i = 0; i < 16; i++) x[127 - 8 * i -: 8] = t[i];
      x = x ^ rk[sel][rnd];
      if (rnd > 0) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = x[127 - 8 * (4 * c + r) -: 8];
          for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j - r + 4) % 4]);
            x[127 - 8 * (4 * c + r) -: 8] = acc;
          end
        end
      end
    end
    return x;
  endfunction

  // Transaction model: busy for Nr+1 cycles after an accepted start.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_left    <= 0;
      m_result  <= '0;
      m_pending <= '0;
    end else if (m_left != 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_result <= m_pending;
    end else if (bus.next) begin
      m_left    <= bus.keylen ? 15 : 11;
      m_pending <= model_decrypt(bus.block, bus.keylen);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("ready", 128'(bus.ready), 128'(m_left == 0));
      check("round", 128'(bus.round), 128'((m_left == 0) ? 0 : m_left - 1));
      check("new_block", bus.new_block, m_result);
    end
  end

  // Called at a falling edge; leaves next high for exactly one rising edge.
  task automatic start_op(input logic [127:0] b, input logic kl);
    bus.next   = 1'b1;
    bus.block  = b;
    bus.keylen = kl;
    run_sel    = kl;
    @(negedge clk);
    bus.next = 1'b0;
  endtask

  // Counts busy cycles and logs key indices; optionally pulses a junk start.
  task automatic wait_done(input int inject_at, output int n);
    n = 0;
    round_log.delete();
    while (bus.ready !== 1'b1 && n < 40) begin
      round_log.push_back(int'(bus.round));
      if (n == inject_at) begin
        bus.next   = 1'b1;
        bus.block  = '1;
        bus.keylen = 1'b1;
      end else begin
        bus.next = 1'b0;
      end
      n++;
      @(negedge clk);
    end
    bus.next = 1'b0;
  endtask

  function automatic logic seq_ok(input int nr);
    if (round_log.size() != nr + 1) return 1'b0;
    for (int k = 0; k <= nr; k++) begin
      if (round_log[k] != nr - k) return 1'b0;
    end
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; check_en = 1'b0; run_sel = 1'b0;
    bus.next = 1'b0; bus.keylen = 1'b0; bus.block = '0;
    reset_n = 1'b1;

    build_sboxes();
    expand_key(KEY128, 4, 0);
    expand_key(KEY256, 8, 1);

    // Pin the model to published values.
    check("model_sbox_00", 128'(sbox[8'h00]), 128'h63);
    check("model_sbox_53", 128'(sbox[8'h53]), 128'hed);
    check("model_rk128_10", rk[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    check("model_c1", model_decrypt(C1_CT, 1'b0), PT);
    check("model_c3", model_decrypt(C3_CT, 1'b1), PT);

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    check_en = 1'b1;

    // Post-reset idle.
    repeat (20) @(negedge clk);
    check("idle_ready", 128'(bus.ready), 128'd1);
    check("idle_round", 128'(bus.round), 128'd0);
    check("idle_new_block", bus.new_block, 128'd0);

    // AES-128.
    start_op(C1_CT, 1'b0);
    wait_done(-1, lat);
    check("latency_128", 128'(lat), 128'd11);
    check("result_128", bus.new_block, PT);
    check("round_seq_128", 128'(seq_ok(10)), 128'd1);

    // AES-256.
    start_op(C3_CT, 1'b1);
    wait_done(-1, lat);
    check("latency_256", 128'(lat), 128'd15);
    check("result_256", bus.new_block, PT);
    check("round_seq_256", 128'(seq_ok(14)), 128'd1);

    // Start pulse while busy is ignored.
    start_op(C1_CT, 1'b0);
    wait_done(3, lat);
    check("busy_latency", 128'(lat), 128'd11);
    check("busy_result", bus.new_block, PT);
    check("busy_round_seq", 128'(seq_ok(10)), 128'd1);

    // Back-to-back: second start in the first ready cycle.
    start_op(C1_CT, 1'b0);
    wait_done(-1, lat);
    start_op(C1_CT, 1'b0);
    check("b2b_hold", bus.new_block, PT);
    wait_done(-1, lat);
    check("b2b_latency", 128'(lat), 128'd11);
    check("b2b_result", bus.new_block, PT);

    // Start pulse in the FINAL cycle is not accepted.
    start_op(C3_CT, 1'b1);
    wait_done(14, lat);
    check("final_next_latency", 128'(lat), 128'd15);
    repeat (3) @(negedge clk);
    check("final_next_ignored", 128'(bus.ready), 128'd1);

    // Reset in the middle of a run.
    start_op(C1_CT, 1'b0);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ready", 128'(bus.ready), 128'd1);
    check("midreset_new_block", bus.new_block, 128'd0);
    check("midreset_round", 128'(bus.round), 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_op(C1_CT, 1'b0);
    wait_done(-1, lat);
    check("after_reset_latency", 128'(lat), 128'd11);
    check("after_reset_result", bus.new_block, PT);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
